// File: rtl/axis_to_native.sv
// axis_to_native: AXI4-Stream pixels in, native vsync/hsync/de video timing out.
// Define AXIS2NATIVE_LINE_CHECK_EN to buffer tlast and check every line's length.
module axis_to_native #(
    parameter int DSIZE      = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int H_TOTAL    = 8,
    parameter int H_ACTIVE   = 4,
    parameter int H_SYNC     = 1,
    parameter int V_TOTAL    = 4,
    parameter int V_ACTIVE   = 2,
    parameter int V_SYNC     = 1
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] axi_tdata,
    input  logic             axi_tvalid,
    output logic             axi_tready,
    input  logic             axi_tuser,
    input  logic             axi_tlast,
    output logic             vsync,
    output logic             hsync,
    output logic             de,
    output logic [DSIZE-1:0] odata,
    output logic             locked,
    output logic             underflow,
    output logic             line_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_START = HW'(H_TOTAL - H_ACTIVE);
    localparam logic [HW-1:0] H_SW    = HW'(H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_START = VW'(V_TOTAL - V_ACTIVE);
    localparam logic [VW-1:0] V_SW    = VW'(V_SYNC);
    localparam logic [AW:0]   FULL    = (AW+1)'(FIFO_DEPTH);

`ifdef AXIS2NATIVE_LINE_CHECK_EN
    localparam int FW = DSIZE + 1;
`else
    localparam int FW = DSIZE;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [HW-1:0]  h_cnt;
    logic [VW-1:0]  v_cnt;
    logic [FW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;

    logic           run;
    logic           empty;
    logic           wr_en;
    logic           active;
    logic           hs;
    logic           vs;
    logic           starve;
    logic           chk_fail;
    logic           abort;
    logic [FW-1:0]  wr_word;
    logic [FW-1:0]  head;

    assign run        = (state == RUN);
    assign empty      = (count == '0);
    assign axi_tready = rst_n & (~run | (count != FULL));
    // Outside RUN only the frame-start beat is kept; others drain.
    assign wr_en      = axi_tvalid & axi_tready & (run | axi_tuser);

    assign active = run & (h_cnt >= H_START) & (v_cnt >= V_START);
    assign hs     = run & (h_cnt < H_SW);
    assign vs     = run & (v_cnt < V_SW);
    assign head   = mem[rd_ptr];
    assign starve = active & empty;

`ifdef AXIS2NATIVE_LINE_CHECK_EN
    assign wr_word  = {axi_tlast, axi_tdata};
    assign chk_fail = active & ~empty
                    & ((h_cnt == H_LAST) ? ~head[DSIZE] : head[DSIZE]);
`else
    logic unused_tlast;
    assign unused_tlast = axi_tlast;
    assign wr_word      = axi_tdata;
    assign chk_fail     = 1'b0;
`endif

    assign abort  = starve | chk_fail;
    assign locked = run;

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            h_cnt     <= '0;
            v_cnt     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            de        <= 1'b0;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            odata     <= '0;
            underflow <= 1'b0;
            line_err  <= 1'b0;
        end else begin
            de        <= active;
            hsync     <= hs;
            vsync     <= vs;
            underflow <= starve;
            line_err  <= chk_fail;
            if (active)
                odata <= starve ? '0 : head[DSIZE-1:0];

            if (abort) begin
                state  <= IDLE;
                h_cnt  <= '0;
                v_cnt  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_en)
                    wr_ptr <= wr_ptr + 1'b1;
                if (active)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + (AW+1)'(wr_en) - (AW+1)'(active);

                if (!run) begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (wr_en)
                        state <= RUN;
                end else if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_to_native.sv
// tb_axis_to_native: frame-time reference model with per-cycle compare,
// plus directed scenarios with literal expectations.
module tb_axis_to_native;

    localparam int DW = 24, DEPTH = 16;
    localparam int HT = 8, HA = 4, HS = 1;
    localparam int VT = 4, VA = 2, VS = 1;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] axi_tdata = '0;
    logic          axi_tvalid = 1'b0;
    logic          axi_tuser = 1'b0;
    logic          axi_tlast = 1'b0;
    logic          axi_tready;
    logic          vsync, hsync, de, locked, underflow, line_err;
    logic [DW-1:0] odata;

    int n_chk = 0;
    int n_pass = 0;

    axis_to_native #(
        .DSIZE(DW), .FIFO_DEPTH(DEPTH),
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC(HS),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC(VS)
    ) dut (
        .clock(clock), .rst_n(rst_n),
        .axi_tdata(axi_tdata), .axi_tvalid(axi_tvalid),
        .axi_tready(axi_tready), .axi_tuser(axi_tuser),
        .axi_tlast(axi_tlast),
        .vsync(vsync), .hsync(hsync), .de(de), .odata(odata),
        .locked(locked), .underflow(underflow), .line_err(line_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        n_chk++;
        if (got !== want)
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        else
            n_pass++;
    endtask

    // Model: frame position is just elapsed time since lock.
    bit            m_run = 0;
    int            m_t = 0;
    logic [DW:0]   m_q[$];
    logic          e_de = 0, e_hs = 0, e_vs = 0, e_uf = 0, e_le = 0;
    logic [DW-1:0] e_odata = '0;

    initial forever begin
        @(posedge clock or negedge rst_n);
        if (!rst_n) begin
            m_run = 0; m_t = 0; m_q.delete();
            e_de = 0; e_hs = 0; e_vs = 0; e_uf = 0; e_le = 0; e_odata = '0;
        end else begin
            bit rdy, acc, act;
            int h, v;
            logic [DW:0] w;
            rdy = !m_run || m_q.size() < DEPTH;
            acc = axi_tvalid && rdy;
            e_de = 0; e_hs = 0; e_vs = 0; e_uf = 0; e_le = 0;
            if (!m_run) begin
                if (acc && axi_tuser) begin
                    m_q.push_back({axi_tlast, axi_tdata});
                    m_run = 1; m_t = 0;
                end
            end else begin
                h = m_t % HT;
                v = (m_t / HT) % VT;
                act = (h >= HT - HA) && (v >= VT - VA);
                e_de = act; e_hs = h < HS; e_vs = v < VS;
                if (act && m_q.size() == 0) begin
                    e_uf = 1; e_odata = '0; m_run = 0;
                end else if (act) begin
                    w = m_q.pop_front();
                    e_odata = w[DW-1:0];
`ifdef AXIS2NATIVE_LINE_CHECK_EN
                    if ((h == HT - 1) != w[DW]) begin
                        e_le = 1; m_run = 0;
                    end
`endif
                end
                if (m_run) begin
                    if (acc) m_q.push_back({axi_tlast, axi_tdata});
                    m_t = (m_t + 1) % (HT * VT);
                end else begin
                    m_q.delete();
                end
            end
        end
    end

    // Every pixel shown with de is logged as {line_err, underflow, odata}.
    logic [DW+1:0] lg[$];

    initial forever begin
        logic e_rdy;
        @(posedge clock);
        #1;
        e_rdy = rst_n && (!m_run || m_q.size() < DEPTH);
        check("cycle",
              64'({axi_tready, de, hsync, vsync, locked, underflow, line_err, odata}),
              64'({e_rdy, e_de, e_hs, e_vs, m_run, e_uf, e_le, e_odata}));
        if (rst_n && de) lg.push_back({line_err, underflow, odata});
    end

    function automatic logic [DW+1:0] lg_at(input int i);
        return (i < lg.size()) ? lg[i] : '1;
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic u, input logic l);
        int n = 0;
        axi_tdata = d; axi_tuser = u; axi_tlast = l; axi_tvalid = 1'b1;
        while (!axi_tready && n < 50) begin
            @(negedge clock); n++;
        end
        if (n == 50) check("send_ready", 64'(axi_tready), 64'(1));
        @(negedge clock);
        axi_tvalid = 1'b0; axi_tuser = 1'b0; axi_tlast = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        axi_tvalid = 1'b0;
        while (locked && n < maxc) begin
            @(negedge clock); n++;
        end
        check("idle_reached", 64'(locked), 64'(0));
        @(negedge clock);
    endtask

    task automatic wait_de(input int maxc, output int n);
        n = 0;
        while (!de && n < maxc) begin
            @(negedge clock); n++;
        end
    endtask

    initial begin
        int n, k;
        bit go;
        logic [DW-1:0] exp8 [8];
        exp8 = '{24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 24'd6, 24'd7, 24'd8};

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_outs",
              64'({axi_tready, de, hsync, vsync, locked, underflow, line_err, odata}),
              64'(0));
        rst_n = 1'b1;
        #1 check("ready_after_release", 64'(axi_tready), 64'(1));
        @(negedge clock);

        // Pixels 1..8, tuser on 1, tlast every 4th
        lg.delete();
        send(24'd1, 1'b1, 1'b0);
        check("locked_after_tuser", 64'(locked), 64'(1));
        for (int i = 2; i <= 8; i++)
            send(DW'(i), 1'b0, (i % 4) == 0);
        wait_idle(100);
        for (int i = 0; i < 8; i++)
            check("frame_pixel", 64'(lg_at(i)), 64'({2'b00, exp8[i]}));
        check("frame_end_underflow", 64'(lg_at(8)), 64'({2'b01, 24'd0}));

        // Stop after 2 pixels: underflow at the third de
        lg.delete();
        send(24'h21, 1'b1, 1'b0);
        send(24'h22, 1'b0, 1'b0);
        wait_de(40, n);
        check("first_de_latency", 64'(n), 64'(20));
        wait_idle(40);
        check("starve_p0", 64'(lg_at(0)), 64'({2'b00, 24'h21}));
        check("starve_p1", 64'(lg_at(1)), 64'({2'b00, 24'h22}));
        check("starve_p2", 64'(lg_at(2)), 64'({2'b01, 24'h0}));
        check("starve_count", 64'(lg.size()), 64'(3));

        // Beats before tuser are dropped
        lg.delete();
        send(24'hA, 1'b0, 1'b0);
        send(24'hB, 1'b0, 1'b0);
        check("no_lock_wo_tuser", 64'(locked), 64'(0));
        send(24'hC, 1'b1, 1'b0);
        send(24'hD, 1'b0, 1'b0);
        send(24'hE, 1'b0, 1'b0);
        send(24'hF, 1'b0, 1'b1);
        wait_idle(100);
        check("first_pix_c", 64'(lg_at(0)), 64'({2'b00, 24'hC}));
        check("second_pix_d", 64'(lg_at(1)), 64'({2'b00, 24'hD}));

        // Constant tvalid with idle consumer fills the FIFO
        lg.delete();
        k = 0;
        for (int c = 0; c < 84; c++) begin
            axi_tdata = DW'(100 + k);
            axi_tuser = (k == 0);
            axi_tlast = (k % 4) == 3;
            axi_tvalid = 1'b1;
            go = axi_tready;
            @(negedge clock);
            if (go) k++;
            if (c == 19) begin
                check("accepts_to_full", 64'(k), 64'(DEPTH));
                check("ready_low_full", 64'(axi_tready), 64'(0));
            end
        end
        axi_tvalid = 1'b0;
        wait_idle(200);
        for (int j = 0; j < k; j++)
            check("no_beat_lost", 64'(lg_at(j)), 64'({2'b00, DW'(100 + j)}));
        check("drain_underflow", 64'(lg_at(k)), 64'({2'b01, 24'd0}));

`ifdef AXIS2NATIVE_LINE_CHECK_EN
        // Short line: tlast on pixel 3
        lg.delete();
        send(24'h51, 1'b1, 1'b0);
        send(24'h52, 1'b0, 1'b0);
        send(24'h53, 1'b0, 1'b1);
        send(24'h54, 1'b0, 1'b0);
        wait_idle(60);
        check("le_p0", 64'(lg_at(0)), 64'({2'b00, 24'h51}));
        check("le_p2", 64'(lg_at(2)), 64'({2'b10, 24'h53}));
        check("le_count", 64'(lg.size()), 64'(3));
`endif

        // Asynchronous reset mid-line, then relock
        send(24'h31, 1'b1, 1'b0);
        send(24'h32, 1'b0, 1'b0);
        send(24'h33, 1'b0, 1'b0);
        send(24'h34, 1'b0, 1'b1);
        wait_de(40, n);
        check("de_before_reset", 64'({de, odata}), 64'({1'b1, 24'h31}));
        #2 rst_n = 1'b0;
        #1 check("async_reset_outs",
                 64'({axi_tready, de, hsync, vsync, locked, underflow, line_err, odata}),
                 64'(0));
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        #1 check("ready_after_rerelease", 64'(axi_tready), 64'(1));
        @(negedge clock);
        lg.delete();
        send(24'h41, 1'b1, 1'b0);
        check("relocked", 64'(locked), 64'(1));
        send(24'h42, 1'b0, 1'b0);
        send(24'h43, 1'b0, 1'b0);
        send(24'h44, 1'b0, 1'b1);
        wait_idle(100);
        check("relock_first_pix", 64'(lg_at(0)), 64'({2'b00, 24'h41}));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axis_to_native.md
AXIS_TO_NATIVE -- requirements
Module: axis_to_native

Interface
REQ-001 SHALL have parameter DSIZE, default 24, pixel data width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, buffer depth in words, power of two and at least 4.
REQ-003 SHALL have parameters H_TOTAL 8 / H_ACTIVE 4 / H_SYNC 1: line length, active pixels, hsync width, all in clocks.
REQ-004 SHALL have parameters V_TOTAL 4 / V_ACTIVE 2 / V_SYNC 1: frame length, active lines, vsync width, all in lines.
REQ-005 clock  in  1  single clock for all logic.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 axi_tdata  in  DSIZE  stream pixel.
REQ-008 axi_tvalid  in  1  stream valid.
REQ-009 axi_tready  out  1  stream ready.
REQ-010 axi_tuser  in  1  first pixel of frame.
REQ-011 axi_tlast  in  1  last pixel of line.
REQ-012 vsync, hsync, de  out  1 each  native timing outputs, active high.
REQ-013 odata  out  DSIZE  native pixel.
REQ-014 locked  out  1  high while in state RUN.
REQ-015 underflow  out  1  one-cycle pulse when de requests a pixel and the FIFO is empty.
REQ-016 line_err  out  1  one-cycle pulse on a tlast mismatch (see Configuration).

Function
REQ-017 A beat SHALL transfer on axi_tvalid & axi_tready.
- axi_tready = IDLE, or RUN with FIFO not full.
REQ-018 States SHALL be IDLE and RUN.
- IDLE: beats are accepted and discarded, except a beat with axi_tuser=1.
- That beat SHALL be written to the FIFO, and the next cycle SHALL be RUN with h_cnt=0, v_cnt=0.
REQ-019 In RUN, h_cnt SHALL count 0..H_TOTAL-1 every cycle, then wrap to 0.
- v_cnt SHALL increment on each h_cnt wrap, and wrap to 0 after V_TOTAL-1.
REQ-020 Combinational active = (h_cnt >= H_TOTAL-H_ACTIVE) & (v_cnt >= V_TOTAL-V_ACTIVE) & RUN.
- Combinational hs = RUN & (h_cnt < H_SYNC).
- Combinational vs = RUN & (v_cnt < V_SYNC).
REQ-021 de, hsync, vsync SHALL be active, hs, vs registered once, giving 1 clock latency from the counters.
REQ-022 When active, the FIFO SHALL be popped; odata SHALL present the popped word in the same cycle that de=1.
- odata SHALL be held when de=0.
REQ-023 Popping an empty FIFO SHALL:
- pulse underflow;
- drive odata=0 with de=1 for that cycle;
- flush the FIFO;
- go to IDLE, clearing the counters.
REQ-024 A simultaneous write and pop SHALL both succeed; the occupancy count is unchanged.
- Writing when full SHALL be impossible, since tready is low.
REQ-025 In RUN, axi_tuser on accepted beats SHALL be ignored for control.

Reset
REQ-026 While rst_n=0 the block SHALL be in IDLE.
- Counters 0, FIFO empty.
- axi_tready=0, vsync=hsync=de=0, odata=0.
- locked=0, underflow=0, line_err=0.
REQ-027 Deassertion SHALL take effect at the next clock edge; tready SHALL be 1 in the first cycle after release.
REQ-028 Reset mid-frame SHALL discard all buffered data and restart from IDLE.

Configuration
REQ-029 Macro AXIS2NATIVE_LINE_CHECK_EN selects line checking.
- Defined: the FIFO SHALL store {tlast, tdata}.
- On the pop at h_cnt=H_TOTAL-1, a stored tlast=0 SHALL fail the check.
- On any other pop, a stored tlast=1 SHALL fail the check.
- A failed check SHALL pulse line_err, flush the FIFO and return to IDLE.
REQ-030 Macro undefined: the FIFO SHALL be DSIZE wide, axi_tlast SHALL be ignored, and line_err SHALL be tied 0.

Verification
REQ-031 Reset then stream pixels 1..8 with tuser on pixel 1 and tlast every 4th pixel, default parameters:
- locked=1 one cycle after the pixel-1 beat;
- de high for h_cnt 4..7 on v_cnt 2..3;
- odata sequence 1,2,3,4 then 5,6,7,8.
REQ-032 Beats 0xA, 0xB without tuser, then 0xC with tuser -> 0xA and 0xB discarded; the first de pixel is 0xC.
REQ-033 Stop tvalid after 2 pixels of a frame -> underflow pulses at the third de.
- Same cycle: odata=0 and de=1.
- Next cycle: locked=0 and the counters are 0.
REQ-034 Hold the consumer idle with tvalid=1 constant -> tready drops after FIFO_DEPTH writes.
- No beat is lost; the write/pop-same-cycle boundary holds the occupancy count.
REQ-035 With AXIS2NATIVE_LINE_CHECK_EN defined, send tlast on pixel 3 instead of 4 -> line_err pulses at the pixel-3 pop, then the block is in IDLE.
REQ-036 Assert rst_n=0 mid-line -> all outputs 0 asynchronously; after release, relock on the next tuser.
